// File: rtl/afifo_frame_unpacker.sv
// Read-side frame unpacker: hunts for SOF, validates LEN and XOR checksum, and packs
// payload bytes little-endian into OUT_BYTES-wide words on a valid/ready master port.
module afifo_frame_unpacker #(
   parameter int               WIDTH     = 8,
   parameter int               OUT_BYTES = 4,
   parameter logic [WIDTH-1:0] SOF       = 8'hA5,
   parameter int               MAX_LEN   = 64,
   parameter int               CNT_W     = 16
) (
   input  logic                       clk_r,
   input  logic                       rst_r,
   input  logic                       rempty,
   input  logic [WIDTH-1:0]           rdata,
   output logic                       pop,
   output logic [OUT_BYTES*WIDTH-1:0] m_data,
   output logic [OUT_BYTES-1:0]       m_keep,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic                       m_last,
   output logic                       m_err,
   output logic                       frame_err,
   output logic [CNT_W-1:0]           frame_cnt,
   output logic [CNT_W-1:0]           drop_cnt
);

   localparam int LANE_W = $clog2(OUT_BYTES);
   localparam int IDX_W  = $clog2(OUT_BYTES + 1);

   typedef enum logic [1:0] {IDLE, LEN, PAY, CSUM} state_t;

   state_t                            state;
   logic [OUT_BYTES-1:0][WIDTH-1:0]   part_q;
   logic [OUT_BYTES-1:0][WIDTH-1:0]   word_n;
   logic [IDX_W-1:0]                  idx;
   logic [7:0]                        remain;
   logic [WIDTH-1:0]                  xsum;
   logic [OUT_BYTES-1:0]              keep_n;

   // Never consume while an unaccepted word sits in the output register.
   assign pop = rst_r && !rempty && (!m_valid || m_ready);

   always_comb begin
      word_n = part_q;
      word_n[idx[LANE_W-1:0]] = rdata;
   end

   // idx holds the number of lanes filled once the frame's payload is complete.
   always_comb begin
      keep_n = '0;
      for (int i = 0; i < OUT_BYTES; i++)
         keep_n[i] = (IDX_W'(i) < idx);
   end

   always_ff @(posedge clk_r or negedge rst_r) begin
      if (!rst_r) begin
         state     <= IDLE;
         part_q    <= '0;
         idx       <= '0;
         remain    <= '0;
         xsum      <= '0;
         m_data    <= '0;
         m_keep    <= '0;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         m_err     <= 1'b0;
         frame_err <= 1'b0;
         frame_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         frame_err <= 1'b0;
         if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_err   <= 1'b0;
         end
         if (pop) begin
            case (state)
               IDLE: begin
                  if (rdata == SOF) state <= LEN;
                  else              drop_cnt <= drop_cnt + CNT_W'(1);
               end
               LEN: begin
                  if (rdata == '0 || rdata > WIDTH'(MAX_LEN)) begin
                     frame_err <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     remain <= rdata;
                     xsum   <= rdata;
                     idx    <= '0;
                     part_q <= '0;
                     state  <= PAY;
                  end
               end
               PAY: begin
                  xsum   <= xsum ^ rdata;
                  remain <= remain - 8'd1;
                  if (remain == 8'd1) begin
                     // Final word waits for the checksum so m_last/m_err ride with it.
                     part_q <= word_n;
                     idx    <= idx + IDX_W'(1);
                     state  <= CSUM;
                  end else if (idx == IDX_W'(OUT_BYTES - 1)) begin
                     m_data  <= word_n;
                     m_keep  <= '1;
                     m_valid <= 1'b1;
                     m_last  <= 1'b0;
                     m_err   <= 1'b0;
                     part_q  <= '0;
                     idx     <= '0;
                  end else begin
                     part_q <= word_n;
                     idx    <= idx + IDX_W'(1);
                  end
               end
               CSUM: begin
                  m_data  <= part_q;
                  m_keep  <= keep_n;
                  m_valid <= 1'b1;
                  m_last  <= 1'b1;
                  m_err   <= (rdata != xsum);
                  if (rdata == xsum) frame_cnt <= frame_cnt + CNT_W'(1);
                  part_q  <= '0;
                  idx     <= '0;
                  state   <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_afifo_frame_unpacker.sv
// Bench for afifo_frame_unpacker: a queue models the FWFT FIFO, a scoreboard queue holds
// expected output words, and directed steps cover framing, errors, backpressure and reset.
module tb_afifo_frame_unpacker;

   logic        clk_r = 1'b0;
   logic        rst_r = 1'b0;
   logic        rempty = 1'b1;
   logic [7:0]  rdata = 8'h00;
   logic        pop;
   logic [31:0] m_data;
   logic [3:0]  m_keep;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic        m_last;
   logic        m_err;
   logic        frame_err;
   logic [15:0] frame_cnt;
   logic [15:0] drop_cnt;

   afifo_frame_unpacker dut (
      .clk_r(clk_r), .rst_r(rst_r), .rempty(rempty), .rdata(rdata), .pop(pop),
      .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last), .m_err(m_err), .frame_err(frame_err),
      .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk_r = ~clk_r;

   logic [7:0]  fifo[$];
   logic [37:0] sb[$];          // {data, keep, last, err}
   logic        pop_seen = 1'b0;
   int          checks = 0;
   int          passes = 0;
   int          ferr_pulses = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // FIFO model: the byte popped at a rising edge leaves the head at the following falling edge.
   always @(posedge clk_r) pop_seen <= pop;
   always @(negedge clk_r) begin
      if (pop_seen && fifo.size() > 0) void'(fifo.pop_front());
      rempty = (fifo.size() == 0);
      rdata  = (fifo.size() == 0) ? 8'h00 : fifo[0];
   end

   // Output monitor: compare each accepted word with the scoreboard head.
   always @(negedge clk_r) begin
      if (rst_r && frame_err) ferr_pulses++;
      if (rst_r && m_valid && m_ready) begin
         if (sb.size() == 0) check("unexpected_word", {26'd0, m_data, m_keep, m_last, m_err}, 64'hDEAD);
         else check("word", {26'd0, m_data, m_keep, m_last, m_err}, {26'd0, sb.pop_front()});
      end
   end

   task automatic push(input logic [7:0] b);
      fifo.push_back(b);
   endtask

   // Pushes SOF/LEN/payload/CSUM and the expected words built from the same bytes.
   task automatic send_frame(input int len, input logic [7:0] seed, input logic [7:0] step,
                             input bit force_cs, input logic [7:0] cs_val);
      logic [7:0]  x, b, cs;
      logic [31:0] w;
      int          lane;
      x = 8'(len); w = '0; lane = 0;
      push(8'hA5); push(8'(len));
      for (int i = 0; i < len; i++) begin
         b = seed + 8'(i) * step;
         push(b);
         x = x ^ b;
         w[lane*8 +: 8] = b;
         lane++;
         if (lane == 4 && i < len - 1) begin
            sb.push_back({w, 4'hF, 1'b0, 1'b0});
            w = '0; lane = 0;
         end
      end
      cs = force_cs ? cs_val : x;
      push(cs);
      sb.push_back({w, 4'((5'd1 << lane) - 5'd1), 1'b1, (cs != x)});
   endtask

   task automatic wait_idle(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 1000 && !done; i++) begin
         @(negedge clk_r); #1;
         if (fifo.size() == 0 && rempty && !m_valid) done = 1'b1;
      end
      check({tag, "_idle"}, {63'd0, done}, 64'd1);
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
   endtask

   task automatic step_clk();
      @(posedge clk_r); #1;
   endtask

   initial begin
      bit seen;
      #1;
      check("rst_outputs", {pop, m_valid, m_last, m_err, frame_err, m_keep, m_data}, 64'd0);
      check("rst_counters", {frame_cnt, drop_cnt}, 64'd0);
      repeat (2) step_clk();
      rst_r = 1'b1;
      step_clk();

      // 1: good 5-byte frame
      send_frame(5, 8'h01, 8'h01, 1'b0, 8'h00);
      wait_idle("t1");
      check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
      check("t1_drop_cnt", 64'(drop_cnt), 64'd0);

      // 2: bad checksum
      send_frame(5, 8'h01, 8'h01, 1'b1, 8'h00);
      wait_idle("t2");
      check("t2_frame_cnt", 64'(frame_cnt), 64'd1);

      // 3: junk before SOF, then AA BB with checksum 02^AA^BB = 13
      push(8'h00); push(8'hFF);
      send_frame(2, 8'hAA, 8'h11, 1'b0, 8'h00);
      wait_idle("t3");
      check("t3_drop_cnt", 64'(drop_cnt), 64'd2);
      check("t3_frame_cnt", 64'(frame_cnt), 64'd2);

      // 4: LEN=0 and LEN=65 dropped
      push(8'hA5); push(8'h00); push(8'hA5); push(8'h41);
      wait_idle("t4");
      check("t4_ferr_pulses", 64'(ferr_pulses), 64'd2);
      check("t4_drop_cnt", 64'(drop_cnt), 64'd2);

      // 5: backpressure after first word
      m_ready = 1'b0;
      send_frame(5, 8'h01, 8'h01, 1'b0, 8'h00);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk_r); #1;
         if (m_valid) seen = 1'b1;
      end
      check("t5_first_word", {63'd0, seen}, 64'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_r); #1;
         check("t5_stall_pop", {63'd0, pop}, 64'd0);
         check("t5_stall_data", 64'(m_data), 64'h04030201);
      end
      check("t5_fifo_left", 64'(fifo.size()), 64'd2);
      @(posedge clk_r); #1;
      m_ready = 1'b1;
      wait_idle("t5");
      check("t5_frame_cnt", 64'(frame_cnt), 64'd3);

      // Boundaries: exact word multiple, two full words, LEN=1, LEN=MAX_LEN, SOF as payload
      send_frame(4, 8'h10, 8'h01, 1'b0, 8'h00);
      send_frame(8, 8'h20, 8'h03, 1'b0, 8'h00);
      send_frame(1, 8'h7E, 8'h00, 1'b0, 8'h00);
      send_frame(64, 8'h00, 8'h01, 1'b0, 8'h00);
      send_frame(3, 8'hA5, 8'h00, 1'b0, 8'h00);
      wait_idle("bnd");
      check("bnd_frame_cnt", 64'(frame_cnt), 64'd8);
      check("bnd_ferr_pulses", 64'(ferr_pulses), 64'd2);

      // 6: reset mid-frame
      push(8'hA5); push(8'h05); push(8'h01); push(8'h02);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk_r); #1;
         if (fifo.size() == 0) seen = 1'b1;
      end
      check("t6_partial_popped", {63'd0, seen}, 64'd1);
      @(posedge clk_r); #1;
      rst_r = 1'b0;
      #1;
      check("t6_rst_outputs", {pop, m_valid, m_last, m_err, frame_err, m_keep, m_data}, 64'd0);
      check("t6_rst_counters", {frame_cnt, drop_cnt}, 64'd0);
      step_clk();
      rst_r = 1'b1;
      step_clk();
      send_frame(5, 8'h01, 8'h01, 1'b0, 8'h00);
      wait_idle("t6");
      check("t6_frame_cnt", 64'(frame_cnt), 64'd1);
      check("t6_drop_cnt", 64'(drop_cnt), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
